// File: rtl/seg_scan_arbiter.sv
// seg_scan_arbiter: blanked 4-digit 7-segment scan shared by two requesters
// Ownership and the displayed snapshot change only at frame boundaries.
module seg_scan_arbiter #(
    parameter int BLANK_CYC   = 2,
    parameter int ON_CYC      = 30,
    parameter int HOLD_FRAMES = 4
) (
    input  logic        my_clk,
    input  logic        my_reset,
    input  logic        req0,
    input  logic [15:0] data0,
    input  logic        req1,
    input  logic [15:0] data1,
    output logic        gnt0,
    output logic        gnt1,
    output logic [3:0]  DIGIT,
    output logic [0:6]  DISPLAY,
    output logic        frame_done
);
    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
    state_t      state;
    logic [1:0]  dig, n_dig;
    logic        drv, n_drv, last_cyc, boundary, last_served, blank, hold_ok, pick0, pick1;
    logic [31:0] cnt, held, held_n;
    logic [15:0] snap;
    logic [3:0]  nib;

    function automatic logic [0:6] seg(input logic [3:0] n);
        case (n)
            4'd0:    seg = 7'b0000001;
            4'd1:    seg = 7'b1001111;
            4'd2:    seg = 7'b0010010;
            4'd3:    seg = 7'b0000110;
            4'd4:    seg = 7'b1001100;
            4'd5:    seg = 7'b0100100;
            4'd6:    seg = 7'b0100000;
            4'd7:    seg = 7'b0001111;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0000100;
            default: seg = 7'b1111110;
        endcase
    endfunction

    // held_n already includes the frame that completes at this boundary
    always_comb begin
        last_cyc = cnt == (drv ? 32'(ON_CYC - 1) : 32'(BLANK_CYC - 1));
        boundary = last_cyc && drv && dig == 2'd3;
        n_drv    = last_cyc ? !drv : drv;
        n_dig    = last_cyc && drv ? dig + 2'd1 : dig;
        nib      = snap[{n_dig, 2'b00} +: 4];
        held_n   = held >= 32'(HOLD_FRAMES) ? held : held + 32'd1;
        hold_ok  = held_n >= 32'(HOLD_FRAMES);
        pick0    = state == OWN0 ? req0 && !(req1 && hold_ok) :
                   state == OWN1 ? req0 && (!req1 || hold_ok) :
                                   req0 && (!req1 || last_served);
        pick1    = req1 && !pick0;
    end

    // DISPLAY can use the current snap: a boundary edge never enters DRIVE
    always_ff @(posedge my_clk or posedge my_reset) begin
        if (my_reset) begin
            cnt         <= '0;
            drv         <= 1'b0;
            dig         <= 2'd0;
            state       <= IDLE;
            held        <= '0;
            last_served <= 1'b1;
            snap        <= '0;
            blank       <= 1'b1;
            gnt0        <= 1'b0;
            gnt1        <= 1'b0;
            DIGIT       <= 4'hf;
            DISPLAY     <= 7'h7f;
            frame_done  <= 1'b0;
        end else begin
            cnt        <= last_cyc ? '0 : cnt + 32'd1;
            drv        <= n_drv;
            dig        <= n_dig;
            frame_done <= boundary;
            DIGIT      <= n_drv ? ~(4'b0001 << n_dig) : 4'hf;
            DISPLAY    <= n_drv && !blank ? seg(nib) : 7'h7f;
            if (boundary) begin
                state       <= pick0 ? OWN0 : pick1 ? OWN1 : IDLE;
                held        <= (pick0 && state == OWN0) || (pick1 && state == OWN1) ? held_n : '0;
                last_served <= pick0 ? 1'b0 : pick1 ? 1'b1 : last_served;
                gnt0        <= pick0;
                gnt1        <= pick1;
                blank       <= !(pick0 || pick1);
                if (pick0 || pick1) snap <= pick0 ? data0 : data1;
            end
        end
    end
endmodule

// File: tb/tb_seg_scan_arbiter.sv
// tb_seg_scan_arbiter: directed frame-by-frame checks of scan timing, decode and arbitration
module tb_seg_scan_arbiter;
    logic        my_clk, my_reset, req0, req1, gnt0, gnt1, frame_done;
    logic [15:0] data0, data1;
    logic [3:0]  DIGIT;
    logic [0:6]  DISPLAY;
    int          checks, failures, pos;

    seg_scan_arbiter #(.BLANK_CYC(2), .ON_CYC(4), .HOLD_FRAMES(4)) dut (
        .my_clk(my_clk), .my_reset(my_reset), .req0(req0), .data0(data0),
        .req1(req1), .data1(data1), .gnt0(gnt0), .gnt1(gnt1),
        .DIGIT(DIGIT), .DISPLAY(DISPLAY), .frame_done(frame_done)
    );

    initial my_clk = 1'b0;
    always #5 my_clk = ~my_clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // pos = cycle number within the frame (1..24) at the current negedge
    task automatic go(input int k);
        repeat (k - pos) @(negedge my_clk);
        pos = k;
    endtask

    task automatic wait_frame();
        int n = 0;
        do begin
            @(negedge my_clk);
            n++;
        end while (!frame_done && n < 100);
        chk("frame_gap", 16'(n), 16'(25 - pos));
        pos = 1;
    endtask

    task automatic chk_gnt(input string tag, input logic [1:0] exp);
        chk(tag, 16'({gnt1, gnt0}), 16'(exp));
    endtask

    initial begin
        checks = 0; failures = 0; pos = 1;
        my_reset = 1'b1; req0 = 1'b0; req1 = 1'b0; data0 = '0; data1 = '0;
        repeat (3) @(negedge my_clk);
        chk("rst_digit", 16'(DIGIT), 16'hf);
        chk("rst_display", 16'(DISPLAY), 16'h7f);
        chk_gnt("rst_gnt", 2'b00);
        chk("rst_frame_done", 16'(frame_done), 16'h0);
        my_reset = 1'b0; pos = 1;
        go(3);
        chk("f0_blank_d0", 16'(DISPLAY), 16'h7f);
        chk("f0_scan_d0", 16'(DIGIT), 16'b1110);
        req0 = 1'b1; data0 = 16'h1234;
        go(21);
        chk("f0_blank_d3", 16'(DISPLAY), 16'h7f);
        chk("f0_scan_d3", 16'(DIGIT), 16'b0111);
        wait_frame();
        chk_gnt("grant0", 2'b01);
        chk("blank_c1", 16'(DIGIT), 16'hf);
        go(2);
        chk("blank_c2", 16'(DIGIT), 16'hf);
        go(3);
        chk("d0_an", 16'(DIGIT), 16'b1110);
        chk("d0_seg4", 16'(DISPLAY), 16'b1001100);
        go(6);
        chk("d0_an_c6", 16'(DIGIT), 16'b1110);
        go(7);
        chk("d1_blank", 16'(DIGIT), 16'hf);
        go(9);
        chk("d1_an", 16'(DIGIT), 16'b1101);
        chk("d1_seg3", 16'(DISPLAY), 16'b0000110);
        go(10);
        data0 = 16'h5678;
        go(15);
        chk("d2_an", 16'(DIGIT), 16'b1011);
        chk("mid_d2_seg2", 16'(DISPLAY), 16'b0010010);
        go(21);
        chk("d3_an", 16'(DIGIT), 16'b0111);
        chk("mid_d3_seg1", 16'(DISPLAY), 16'b1001111);
        wait_frame();
        chk_gnt("hold0_a", 2'b01);
        go(3);
        chk("new_d0_seg8", 16'(DISPLAY), 16'b0000000);
        go(21);
        chk("new_d3_seg5", 16'(DISPLAY), 16'b0100100);
        go(22);
        data0 = 16'h00a9;
        wait_frame();
        go(3);
        chk("a9_d0", 16'(DISPLAY), 16'b0000100);
        go(9);
        chk("a9_d1_dash", 16'(DISPLAY), 16'b1111110);
        go(15);
        chk("a9_d2", 16'(DISPLAY), 16'b0000001);
        go(21);
        chk("a9_d3", 16'(DISPLAY), 16'b0000001);
        go(22);
        req0 = 1'b0;
        wait_frame();
        chk_gnt("release_idle", 2'b00);
        go(3);
        chk("idle_d0", 16'(DISPLAY), 16'h7f);
        chk("idle_scan", 16'(DIGIT), 16'b1110);
        go(9);
        chk("idle_d1", 16'(DISPLAY), 16'h7f);
        go(15);
        chk("idle_d2", 16'(DISPLAY), 16'h7f);
        go(24);
        req0 = 1'b1; req1 = 1'b1; data1 = 16'h0007;
        wait_frame();
        chk_gnt("rr_after0", 2'b10);
        go(3);
        chk("g1_d0_seg7", 16'(DISPLAY), 16'b0001111);
        go(21);
        chk("g1_d3_seg0", 16'(DISPLAY), 16'b0000001);
        for (int i = 0; i < 3; i++) begin
            wait_frame();
            chk_gnt("hold1", 2'b10);
        end
        wait_frame();
        chk_gnt("switch_to0", 2'b01);
        go(4);
        chk("pre_rst_an", 16'(DIGIT), 16'b1110);
        chk("pre_rst_seg9", 16'(DISPLAY), 16'b0000100);
        #2 my_reset = 1'b1;
        #1;
        chk("mid_rst_digit", 16'(DIGIT), 16'hf);
        chk("mid_rst_display", 16'(DISPLAY), 16'h7f);
        chk_gnt("mid_rst_gnt", 2'b00);
        chk("mid_rst_fd", 16'(frame_done), 16'h0);
        repeat (2) @(negedge my_clk);
        my_reset = 1'b0; pos = 1;
        go(3);
        chk("post_rst_blank_d0", 16'(DISPLAY), 16'h7f);
        go(21);
        chk("post_rst_blank_d3", 16'(DISPLAY), 16'h7f);
        wait_frame();
        chk_gnt("post_rst_gnt0", 2'b01);
        for (int i = 0; i < 3; i++) begin
            wait_frame();
            chk_gnt("hold0_b", 2'b01);
        end
        wait_frame();
        chk_gnt("hold_switch1", 2'b10);
        for (int i = 0; i < 3; i++) begin
            wait_frame();
            chk_gnt("hold1_b", 2'b10);
        end
        wait_frame();
        chk_gnt("hold_switch0", 2'b01);
        go(2);
        req0 = 1'b0;
        wait_frame();
        chk_gnt("release_to1", 2'b10);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
